cdb_host_if: RTL and testbench



---
 rtl/cdb_host_if.sv | 190 +++++++++++++++++++
 tb/tb_cdb_host_if.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_host_if.sv
// CD-block host interface on the A-bus CS2 window: HIRQ/HIRQMASK/CR1-CR4 registers,
// command/response handshake with the drive back end, and a FWFT sector-data FIFO.
module cdb_host_if #(
   parameter int          FIFO_AW  = 9,
   parameter logic [9:0]  BASE     = 10'h189,
   parameter logic [15:0] HIRQ_RST = 16'hFFFF,
   parameter logic [63:0] CR_RST   = 64'h0043_4442_4C4F_434B
) (
   input  logic               CLK,
   input  logic               RST_N,
   input  logic               CE,
   input  logic [25:0]        A,
   input  logic [15:0]        DI,
   output logic [15:0]        DO,
   input  logic               CS_N,
   input  logic               RD_N,
   input  logic               WRL_N,
   input  logic               WRU_N,
   output logic               IRQ_N,
   output logic               CMD_REQ,
   output logic [63:0]        CMD,
   input  logic               RESP_VALID,
   input  logic [63:0]        RESP,
   input  logic [15:0]        RESP_IRQ,
   input  logic [15:0]        IRQ_SET,
   input  logic               DATA_WR,
   input  logic [15:0]        DATA_IN,
   input  logic               FIFO_CLR,
   output logic               DATA_FULL,
   output logic [FIFO_AW:0]   DATA_LEVEL
);

   localparam int DEPTH = 1 << FIFO_AW;

   localparam logic [15:0] OFF_DTR  = 16'h0000;
   localparam logic [15:0] OFF_HIRQ = 16'h0008;
   localparam logic [15:0] OFF_MASK = 16'h000C;
   localparam logic [15:0] OFF_CR1  = 16'h0018;
   localparam logic [15:0] OFF_CR2  = 16'h001C;
   localparam logic [15:0] OFF_CR3  = 16'h0020;
   localparam logic [15:0] OFF_CR4  = 16'h0024;

   localparam logic [FIFO_AW:0]   LVL_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
   localparam logic [FIFO_AW:0]   LVL_FULL = {1'b1, {FIFO_AW{1'b0}}};
   localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t             state_q, state_d;
   logic               sel;
   logic [15:0]        off;
   logic               wr_hi_q, rd_dtr_q;
   logic               wr_stb, wr_hirq, wr_mask;
   logic [3:0]         wr_cr;
   logic               issue;
   logic [15:0]        hirq_q, hirq_d;
   logic [15:0]        mask_q, mask_d;
   logic [3:0][15:0]   cr_q, cr_w, cr_d;
   logic [15:0]        mem [DEPTH];
   logic [FIFO_AW-1:0] wp_q, rp_q;
   logic [FIFO_AW:0]   level_q;
   logic               empty, full, pop_ok, push_ok;
   logic               unused_a0;

   assign unused_a0 = A[0];

   function automatic logic [15:0] lane_merge(input logic [15:0] old, input logic [15:0] din,
                                              input logic wrl_n, input logic wru_n);
      return {wru_n ? old[15:8] : din[15:8], wrl_n ? old[7:0] : din[7:0]};
   endfunction

   assign sel = !CS_N && (A[25:16] == BASE);
   assign off = {A[15:1], 1'b0};

   // A write commits only on the first strobe cycle after both strobes were seen high.
   assign wr_stb  = sel && (!WRL_N || !WRU_N) && wr_hi_q;
   assign wr_hirq = wr_stb && (off == OFF_HIRQ);
   assign wr_mask = wr_stb && (off == OFF_MASK);
   // cr_*[3] is CR1 (MSBs of CMD/RESP), cr_*[0] is CR4.
   assign wr_cr[3] = wr_stb && (off == OFF_CR1);
   assign wr_cr[2] = wr_stb && (off == OFF_CR2);
   assign wr_cr[1] = wr_stb && (off == OFF_CR3);
   assign wr_cr[0] = wr_stb && (off == OFF_CR4);

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         ST_IDLE: if (wr_cr[0] && hirq_q[0]) begin
            issue   = 1'b1;
            state_d = ST_BUSY;
         end
         ST_BUSY: if (RESP_VALID) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cr_w = cr_q;
      for (int i = 0; i < 4; i++)
         if (wr_cr[i]) cr_w[i] = lane_merge(cr_q[i], DI, WRL_N, WRU_N);
      cr_d = RESP_VALID ? RESP : cr_w;
   end

   // Clears (host write, command issue) are applied before sets so a set always wins.
   always_comb begin
      hirq_d = hirq_q;
      if (wr_hirq) hirq_d = hirq_d & DI;
      if (issue)   hirq_d[0] = 1'b0;
      hirq_d = hirq_d | IRQ_SET | (RESP_VALID ? (RESP_IRQ | 16'h0001) : 16'h0000);
   end

   assign mask_d = wr_mask ? lane_merge(mask_q, DI, WRL_N, WRU_N) : mask_q;

   assign empty   = (level_q == '0);
   assign full    = (level_q == LVL_FULL);
   // A DTR read pops on the rising edge of RD_N that ends it.
   assign pop_ok  = rd_dtr_q && RD_N && !empty;
   assign push_ok = DATA_WR && (!full || pop_ok);

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q  <= ST_IDLE;
         wr_hi_q  <= 1'b1;
         rd_dtr_q <= 1'b0;
         hirq_q   <= HIRQ_RST;
         mask_q   <= 16'hFFFF;
         cr_q     <= CR_RST;
         CMD_REQ  <= 1'b0;
         CMD      <= '0;
         IRQ_N    <= 1'b1;
      end else if (CE) begin
         state_q  <= state_d;
         wr_hi_q  <= WRL_N && WRU_N;
         rd_dtr_q <= sel && (off == OFF_DTR) && !RD_N;
         hirq_q   <= hirq_d;
         mask_q   <= mask_d;
         cr_q     <= cr_d;
         CMD_REQ  <= issue;
         if (issue) CMD <= cr_w;
         IRQ_N    <= ~|(hirq_d & mask_d);
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wp_q    <= '0;
         rp_q    <= '0;
         level_q <= '0;
      end else if (CE) begin
         if (FIFO_CLR) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
         end else begin
            if (push_ok) wp_q <= wp_q + PTR_ONE;
            if (pop_ok)  rp_q <= rp_q + PTR_ONE;
            case ({push_ok, pop_ok})
               2'b10:   level_q <= level_q + LVL_ONE;
               2'b01:   level_q <= level_q - LVL_ONE;
               default: level_q <= level_q;
            endcase
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST_N && CE && push_ok && !FIFO_CLR) mem[wp_q] <= DATA_IN;
   end

   assign DATA_FULL  = full;
   assign DATA_LEVEL = level_q;

   always_comb begin
      DO = 16'h0000;
      if (sel) begin
         case (off)
            OFF_DTR:  DO = empty ? 16'hFFFF : mem[rp_q];
            OFF_HIRQ: DO = hirq_q;
            OFF_MASK: DO = mask_q;
            OFF_CR1:  DO = cr_q[3];
            OFF_CR2:  DO = cr_q[2];
            OFF_CR3:  DO = cr_q[1];
            OFF_CR4:  DO = cr_q[0];
            default:  DO = 16'h0000;
         endcase
      end
   end

endmodule

// File: tb/tb_cdb_host_if.sv
// Directed bench for cdb_host_if: register reset, command handshake, HIRQ rules, FIFO, strobes.
module tb_cdb_host_if;

   localparam int AW = 2;

   logic          CLK = 1'b0;
   logic          RST_N, CE;
   logic [25:0]   A;
   logic [15:0]   DI, DO;
   logic          CS_N, RD_N, WRL_N, WRU_N;
   logic          IRQ_N, CMD_REQ;
   logic [63:0]   CMD;
   logic          RESP_VALID;
   logic [63:0]   RESP;
   logic [15:0]   RESP_IRQ, IRQ_SET;
   logic          DATA_WR;
   logic [15:0]   DATA_IN;
   logic          FIFO_CLR, DATA_FULL;
   logic [AW:0]   DATA_LEVEL;

   int total = 0;
   int bad   = 0;

   cdb_host_if #(.FIFO_AW(AW)) dut (
      .CLK(CLK), .RST_N(RST_N), .CE(CE), .A(A), .DI(DI), .DO(DO),
      .CS_N(CS_N), .RD_N(RD_N), .WRL_N(WRL_N), .WRU_N(WRU_N),
      .IRQ_N(IRQ_N), .CMD_REQ(CMD_REQ), .CMD(CMD),
      .RESP_VALID(RESP_VALID), .RESP(RESP), .RESP_IRQ(RESP_IRQ), .IRQ_SET(IRQ_SET),
      .DATA_WR(DATA_WR), .DATA_IN(DATA_IN), .FIFO_CLR(FIFO_CLR),
      .DATA_FULL(DATA_FULL), .DATA_LEVEL(DATA_LEVEL)
   );

   always #5 CLK = ~CLK;

   initial begin
      #200000;
      $display("FAIL timeout total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "timeout");
   end

   function automatic logic [25:0] ad(input logic [15:0] o);
      return {10'h189, o};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic bus_wr(input logic [15:0] o, input logic [15:0] d,
                         input logic wrl, input logic wru, input logic [15:0] irqs);
      A = ad(o); DI = d; CS_N = 1'b0; WRL_N = ~wrl; WRU_N = ~wru; IRQ_SET = irqs;
      tick();
      WRL_N = 1'b1; WRU_N = 1'b1; CS_N = 1'b1; IRQ_SET = '0;
      tick();
   endtask

   task automatic bus_rd(input logic [15:0] o, output logic [15:0] d);
      A = ad(o); CS_N = 1'b0; RD_N = 1'b0;
      #1 d = DO;
      tick();
      RD_N = 1'b1; CS_N = 1'b1;
      tick();
   endtask

   task automatic peek(input logic [15:0] o, output logic [15:0] d);
      A = ad(o); CS_N = 1'b0;
      #1 d = DO;
      CS_N = 1'b1;
   endtask

   task automatic respond(input logic [63:0] r, input logic [15:0] ri);
      RESP_VALID = 1'b1; RESP = r; RESP_IRQ = ri;
      tick();
      RESP_VALID = 1'b0; RESP = '0; RESP_IRQ = '0;
   endtask

   task automatic push(input logic [15:0] d);
      DATA_WR = 1'b1; DATA_IN = d;
      tick();
      DATA_WR = 1'b0;
   endtask

   initial begin
      logic [15:0] rd;
      RST_N = 1'b0; CE = 1'b1; A = '0; DI = '0; CS_N = 1'b1; RD_N = 1'b1;
      WRL_N = 1'b1; WRU_N = 1'b1; RESP_VALID = 1'b0; RESP = '0; RESP_IRQ = '0;
      IRQ_SET = '0; DATA_WR = 1'b0; DATA_IN = '0; FIFO_CLR = 1'b0;
      tick(); tick();
      check("rst_irq_n", 64'(IRQ_N), 64'd1);
      check("rst_cmd_req", 64'(CMD_REQ), 64'd0);
      check("rst_cmd", CMD, 64'd0);
      check("rst_level", 64'(DATA_LEVEL), 64'd0);
      check("rst_full", 64'(DATA_FULL), 64'd0);
      RST_N = 1'b1;
      peek(16'h0018, rd); check("rst_cr1", 64'(rd), 64'h0043);
      peek(16'h001C, rd); check("rst_cr2", 64'(rd), 64'h4442);
      peek(16'h0020, rd); check("rst_cr3", 64'(rd), 64'h4C4F);
      peek(16'h0024, rd); check("rst_cr4", 64'(rd), 64'h434B);
      peek(16'h0008, rd); check("rst_hirq", 64'(rd), 64'hFFFF);
      peek(16'h000C, rd); check("rst_mask", 64'(rd), 64'hFFFF);
      bus_rd(16'h0000, rd); check("rst_dtr_empty", 64'(rd), 64'hFFFF);
      check("rst_dtr_level", 64'(DATA_LEVEL), 64'd0);

      // mask byte lanes and IRQ_N
      bus_wr(16'h000C, 16'h0000, 1'b1, 1'b1, 16'h0);
      check("mask0_irq_n", 64'(IRQ_N), 64'd1);
      bus_wr(16'h000C, 16'hAB12, 1'b0, 1'b1, 16'h0);
      peek(16'h000C, rd); check("mask_upper_lane", 64'(rd), 64'hAB00);
      check("mask_upper_irq_n", 64'(IRQ_N), 64'd0);
      bus_wr(16'h000C, 16'h0000, 1'b1, 1'b1, 16'h0);

      // command handshake
      bus_wr(16'h0008, 16'hFFFD, 1'b1, 1'b1, 16'h0);
      peek(16'h0008, rd); check("hirq_w0c", 64'(rd), 64'hFFFD);
      bus_wr(16'h0018, 16'h1000, 1'b1, 1'b1, 16'h0);
      bus_wr(16'h001C, 16'h0000, 1'b1, 1'b1, 16'h0);
      bus_wr(16'h0020, 16'h0000, 1'b1, 1'b1, 16'h0);
      A = ad(16'h0024); DI = 16'h0001; CS_N = 1'b0; WRL_N = 1'b0; WRU_N = 1'b0;
      tick();
      check("issue_cmd_req", 64'(CMD_REQ), 64'd1);
      check("issue_cmd", CMD, 64'h1000_0000_0000_0001);
      WRL_N = 1'b1; WRU_N = 1'b1; CS_N = 1'b1;
      tick();
      check("issue_pulse_end", 64'(CMD_REQ), 64'd0);
      peek(16'h0008, rd); check("issue_hirq0_clr", 64'(rd), 64'hFFFC);
      IRQ_SET = 16'h0001; tick(); IRQ_SET = '0;
      peek(16'h0008, rd); check("irq_set_async", 64'(rd), 64'hFFFD);

      // busy: CR4 write stored but no command
      A = ad(16'h0024); DI = 16'h0002; CS_N = 1'b0; WRL_N = 1'b0; WRU_N = 1'b0;
      tick();
      check("busy_no_req", 64'(CMD_REQ), 64'd0);
      WRL_N = 1'b1; WRU_N = 1'b1; CS_N = 1'b1;
      tick();
      peek(16'h0024, rd); check("busy_cr4_stored", 64'(rd), 64'h0002);
      check("busy_cmd_kept", CMD, 64'h1000_0000_0000_0001);
      bus_wr(16'h000C, 16'h0002, 1'b1, 1'b1, 16'h0);
      check("pre_resp_irq_n", 64'(IRQ_N), 64'd1);
      respond(64'h0100_0000_0000_0000, 16'h0002);
      check("resp_irq_n", 64'(IRQ_N), 64'd0);
      peek(16'h0018, rd); check("resp_cr1", 64'(rd), 64'h0100);
      peek(16'h0024, rd); check("resp_cr4", 64'(rd), 64'h0000);
      peek(16'h0008, rd); check("resp_hirq", 64'(rd), 64'hFFFF);

      // back in IDLE: next CR4 write issues
      A = ad(16'h0024); DI = 16'h00AA; CS_N = 1'b0; WRL_N = 1'b0; WRU_N = 1'b0;
      tick();
      check("reissue_req", 64'(CMD_REQ), 64'd1);
      check("reissue_cmd", CMD, 64'h0100_0000_0000_00AA);
      WRL_N = 1'b1; WRU_N = 1'b1; CS_N = 1'b1;
      tick();

      // reset mid-command, then unsolicited status
      RST_N = 1'b0; tick(); RST_N = 1'b1;
      check("midrst_cmd", CMD, 64'd0);
      peek(16'h0018, rd); check("midrst_cr1", 64'(rd), 64'h0043);
      respond(64'h1111_2222_3333_4444, 16'h0000);
      peek(16'h0018, rd); check("unsol_cr1", 64'(rd), 64'h1111);
      peek(16'h0024, rd); check("unsol_cr4", 64'(rd), 64'h4444);
      A = ad(16'h0024); DI = 16'h0007; CS_N = 1'b0; WRL_N = 1'b0; WRU_N = 1'b0;
      tick();
      check("postrst_req", 64'(CMD_REQ), 64'd1);
      check("postrst_cmd", CMD, 64'h1111_2222_3333_0007);
      WRL_N = 1'b1; WRU_N = 1'b1; CS_N = 1'b1;
      tick();
      respond(64'h0, 16'h0);
      peek(16'h0008, rd); check("postrst_hirq", 64'(rd), 64'hFFFF);

      // clear/set collision
      bus_wr(16'h0008, 16'h0000, 1'b1, 1'b1, 16'h0010);
      peek(16'h0008, rd); check("collide_hirq", 64'(rd), 64'h0010);

      // decode
      A = {10'h188, 16'h0008}; CS_N = 1'b0; #1 check("bad_base", 64'(DO), 64'h0);
      A = ad(16'h0004); #1 check("unmapped", 64'(DO), 64'h0);
      CS_N = 1'b1; A = ad(16'h0008); #1 check("no_cs", 64'(DO), 64'h0);

      // FIFO fill/overflow/drain
      for (int i = 0; i < 5; i++) push(16'h00A0 + 16'(i));
      check("fill_level", 64'(DATA_LEVEL), 64'd4);
      check("fill_full", 64'(DATA_FULL), 64'd1);
      for (int i = 0; i < 4; i++) begin
         bus_rd(16'h0000, rd);
         check($sformatf("drain%0d", i), 64'(rd), 64'(16'h00A0 + 16'(i)));
      end
      check("drain_level", 64'(DATA_LEVEL), 64'd0);
      check("drain_full", 64'(DATA_FULL), 64'd0);
      bus_rd(16'h0000, rd); check("drain_empty", 64'(rd), 64'hFFFF);
      check("drain_empty_level", 64'(DATA_LEVEL), 64'd0);

      // simultaneous push and pop at level 2 (pointers have wrapped)
      push(16'h00B0); push(16'h00B1);
      A = ad(16'h0000); CS_N = 1'b0; RD_N = 1'b0;
      #1 check("pp_head", 64'(DO), 64'h00B0);
      tick();
      RD_N = 1'b1; CS_N = 1'b1; DATA_WR = 1'b1; DATA_IN = 16'h00B2;
      tick();
      DATA_WR = 1'b0;
      check("pp_level", 64'(DATA_LEVEL), 64'd2);
      peek(16'h0000, rd); check("pp_next_head", 64'(rd), 64'h00B1);

      // CE low freezes state
      CE = 1'b0; DATA_WR = 1'b1; DATA_IN = 16'h00DD; tick(); CE = 1'b1; DATA_WR = 1'b0;
      check("ce_hold_level", 64'(DATA_LEVEL), 64'd2);

      // flush beats same-cycle push
      FIFO_CLR = 1'b1; DATA_WR = 1'b1; DATA_IN = 16'h00EE; tick();
      FIFO_CLR = 1'b0; DATA_WR = 1'b0;
      check("clr_level", 64'(DATA_LEVEL), 64'd0);
      peek(16'h0000, rd); check("clr_dtr", 64'(rd), 64'hFFFF);

      // long strobes
      push(16'h00C0); push(16'h00C1);
      A = ad(16'h0000); CS_N = 1'b0; RD_N = 1'b0;
      repeat (10) tick();
      check("long_rd_hold", 64'(DATA_LEVEL), 64'd2);
      RD_N = 1'b1; CS_N = 1'b1;
      tick();
      check("long_rd_once", 64'(DATA_LEVEL), 64'd1);
      peek(16'h0000, rd); check("long_rd_head", 64'(rd), 64'h00C1);
      A = ad(16'h001C); DI = 16'h5555; CS_N = 1'b0; WRL_N = 1'b0; WRU_N = 1'b0;
      tick();
      DI = 16'h6666;
      repeat (9) tick();
      WRL_N = 1'b1; WRU_N = 1'b1; CS_N = 1'b1;
      tick();
      peek(16'h001C, rd); check("long_wr_once", 64'(rd), 64'h5555);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
